// File: rtl/unipolar_rz_multi.sv
`timescale 1ns/1ps
// Unipolar return-to-zero serializer: CHANNELS lanes share one bit clock and
// one word handshake, each stream followed by a low latch gap (WS281x style).
module unipolar_rz_multi #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned DATA_WIDTH     = 24,
    parameter real         CLOCK_RATE     = 100e6,
    parameter real         PERIOD_TIME    = 1.2e-6,
    parameter real         ZERO_HIGH_TIME = 0.3e-6,
    parameter real         ONE_HIGH_TIME  = 0.6e-6,
    parameter real         RESET_TIME     = 80e-6,
    parameter bit          MSB_FIRST      = 1'b0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data,
    input  logic [CHANNELS-1:0]            mask,
    input  logic                           enable,
    output logic                           ready,
    output logic [CHANNELS-1:0]            line,
    output logic                           done
);

    localparam int unsigned P  = $rtoi(PERIOD_TIME * CLOCK_RATE + 0.5);
    localparam int unsigned Z  = $rtoi(ZERO_HIGH_TIME * CLOCK_RATE + 0.5);
    localparam int unsigned O  = $rtoi(ONE_HIGH_TIME * CLOCK_RATE + 0.5);
    localparam int unsigned R  = $rtoi(RESET_TIME * CLOCK_RATE + 0.5);
    localparam int unsigned TW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned LW = (R > 0) ? $clog2(R + 1) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(P - 1);
    localparam logic [TW-1:0] Z_T    = TW'(Z);
    localparam logic [TW-1:0] O_T    = TW'(O);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] L_LAST = LW'(R - 1);

    if (Z < 1 || Z >= O || O >= P || R < 1) begin : g_bad_timing
        $fatal(1, "unipolar_rz_multi: need 1 <= Z < O < P and R >= 1 (Z=%0d O=%0d P=%0d R=%0d)",
               Z, O, P, R);
    end

    typedef enum logic [1:0] {S_LATCH, S_IDLE, S_BIT} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           t_q, t_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sr_q [CHANNELS];
    logic [DATA_WIDTH-1:0]   sr_d [CHANNELS];
    logic [CHANNELS-1:0]     mask_q, mask_d;
    logic [CHANNELS-1:0]     line_q, line_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    load_c;

    // Next state; outputs are derived from the next-state values so the line
    // registers line up with the bit timer without an extra cycle of delay.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        load_c  = 1'b0;

        case (state_q)
            S_LATCH: begin
                if (cnt_q == L_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            S_IDLE: load_c = ready_q && enable;
            S_BIT: begin
                if (t_q != T_LAST) begin
                    t_d = t_q + TW'(1);
                end else if (idx_q != I_LAST) begin
                    t_d   = '0;
                    idx_d = idx_q + IW'(1);
                    for (int c = 0; c < int'(CHANNELS); c++) begin
                        sr_d[c] = MSB_FIRST ? (sr_q[c] << 1) : (sr_q[c] >> 1);
                    end
                end else if (ready_q && enable) begin
                    load_c = 1'b1;
                end else begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_LATCH;
        endcase

        if (load_c) begin
            state_d = S_BIT;
            t_d     = '0;
            idx_d   = '0;
            mask_d  = mask;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                sr_d[c] = data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        ready_d = (state_d == S_IDLE) ||
                  (state_d == S_BIT && t_d == T_LAST && idx_d == I_LAST);

        for (int c = 0; c < int'(CHANNELS); c++) begin
            line_d[c] = (state_d == S_BIT) && mask_d[c] &&
                        (t_d < ((MSB_FIRST ? sr_d[c][DATA_WIDTH-1] : sr_d[c][0]) ? O_T : Z_T));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_LATCH;
            t_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '{default: '0};
            mask_q  <= '0;
            line_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign line  = line_q;
    assign done  = done_q;

endmodule
